// File: rtl/fp64_classify_rr_arbiter_if.sv
// Request/response bundle between FP issue lanes, the shared classifier and FCLASS writeback.
// Latency: none, wires only.
// Backpressure: valid/ready on both the request and response sides.
interface fp64_classify_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*64-1:0] req_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [63:0]           rsp_data;
  logic [9:0]            rsp_class;
  logic                  busy;
  logic                  cnt_clr;
  logic [CNT_W-1:0]      snan_cnt;

  // Requesters and the response consumer.
  modport master (
    output req_valid, req_data, rsp_ready, cnt_clr,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_class, busy, snan_cnt
  );

  // The arbiter/classifier block.
  modport slave (
    input  req_valid, req_data, rsp_ready, cnt_clr,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_class, busy, snan_cnt
  );
endinterface

// File: rtl/fp64_classify_rr_arbiter.sv
// One fp64 classifier shared round-robin by NUM_REQ requesters, with an sNaN counter.
// Latency: 2 cycles from request handshake to rsp_valid; 1 op/cycle sustained.
// Backpressure: rsp_ready low stalls S2, then S1; req_ready drops once both are full.

// Pure combinational IEEE-754 binary64 classifier, one-hot in FCLASS bit order.
module fp64_classify (
  input  logic [63:0] x,
  output logic [9:0]  cls
);
  logic        sgn;
  logic [10:0] expo;
  logic [51:0] mant;
  logic        exp_ones, exp_zero, mant_zero;
  logic        is_inf, is_nan, is_zero, is_den, is_norm;

  assign sgn       = x[63];
  assign expo      = x[62:52];
  assign mant      = x[51:0];
  assign exp_ones  = &expo;
  assign exp_zero  = ~|expo;
  assign mant_zero = ~|mant;

  assign is_inf  = exp_ones & mant_zero;
  assign is_nan  = exp_ones & ~mant_zero;
  assign is_zero = exp_zero & mant_zero;
  assign is_den  = exp_zero & ~mant_zero;
  assign is_norm = ~exp_ones & ~exp_zero;

  // NaNs ignore the sign; mant[51] separates quiet from signalling.
  assign cls = {is_nan & mant[51], is_nan & ~mant[51],
                ~sgn & is_inf, ~sgn & is_norm, ~sgn & is_den, ~sgn & is_zero,
                sgn & is_zero, sgn & is_den, sgn & is_norm, sgn & is_inf};
endmodule

module fp64_classify_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  fp64_classify_rr_arbiter_if.slave bus
);
  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;
  logic               s1_v, s2_v;
  logic [63:0]        s1_data;
  logic [ID_W-1:0]    s1_id;
  logic               s1_en, s2_en;
  logic               req_hs, rsp_hs;
  logic [9:0]         cls;

  assign s2_en = ~s2_v | bus.rsp_ready;
  assign s1_en = ~s1_v | s2_en;

  // Round-robin scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    int idx;
    grant   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int o = 0; o < NUM_REQ; o++) begin
      idx = int'(rr_ptr) + o;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_any && bus.req_valid[idx]) begin
        grant[idx] = 1'b1;
        gnt_id     = ID_W'(idx);
        gnt_any    = 1'b1;
      end
    end
  end

  // Ready is gated by reset so no requester sees an accept while held in reset.
  assign bus.req_ready = grant & {NUM_REQ{s1_en & rst_n}};
  assign req_hs        = gnt_any & s1_en & rst_n;
  assign rsp_hs        = s2_v & bus.rsp_ready;

  fp64_classify u_cls (
    .x   (s1_data),
    .cls (cls)
  );

  // Pointer moves just past the requester that was served, so it goes last next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (req_hs) begin
      if (int'(gnt_id) == NUM_REQ - 1) rr_ptr <= '0;
      else                             rr_ptr <= gnt_id + ID_W'(1);
    end
  end

  // S1: capture the granted operand and its requester index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_data <= '0;
      s1_id   <= '0;
    end else if (s1_en) begin
      s1_v <= req_hs;
      if (req_hs) begin
        s1_data <= bus.req_data[int'(gnt_id)*64 +: 64];
        s1_id   <= gnt_id;
      end
    end
  end

  // S2: register classifier result; these registers are the response port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v          <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_class <= '0;
    end else if (s2_en) begin
      s2_v <= s1_v;
      if (s1_v) begin
        bus.rsp_id    <= s1_id;
        bus.rsp_data  <= s1_data;
        bus.rsp_class <= cls;
      end
    end
  end

  // Saturating sNaN counter; clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.snan_cnt <= '0;
    end else if (bus.cnt_clr) begin
      bus.snan_cnt <= '0;
    end else if (rsp_hs && bus.rsp_class[8] && (bus.snan_cnt != {CNT_W{1'b1}})) begin
      bus.snan_cnt <= bus.snan_cnt + CNT_W'(1);
    end
  end

  assign bus.rsp_valid = s2_v;
  assign bus.busy      = s1_v | s2_v;
endmodule

// File: tb/tb_fp64_classify_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference.
// Latency: model expects a response visible one edge after the accepting edge has passed.
// Backpressure: occupancy of the model queue decides whether a request may be accepted.
module tb_fp64_classify_rr_arbiter;
  localparam int NR    = 4;
  localparam int IDW   = 2;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp64_classify_rr_arbiter_if #(.NUM_REQ(NR), .ID_W(IDW), .CNT_W(CW)) bus ();

  fp64_classify_rr_arbiter #(.NUM_REQ(NR), .ID_W(IDW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          id;
    logic [63:0] data;
    int          acc;
  } item_t;

  item_t q[$];
  int    cyc    = 0;
  int    m_ptr  = 0;
  int    m_cnt  = 0;
  int    n_acc  = 0;
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Class from the numeric rules of binary64.
  function automatic logic [9:0] ref_class(input logic [63:0] x);
    int          e;
    logic [51:0] m;
    e = int'(x[62:52]);
    m = x[51:0];
    if (e == 2047) begin
      if (m == 0)      return x[63] ? 10'd1 : 10'd128;
      else if (m[51])  return 10'd512;
      else             return 10'd256;
    end
    if (e == 0) begin
      if (m == 0) return x[63] ? 10'd8 : 10'd16;
      return x[63] ? 10'd4 : 10'd32;
    end
    return x[63] ? 10'd2 : 10'd64;
  endfunction

  // Valid requester at the smallest cyclic distance from the pointer.
  function automatic int ref_grant(input logic [NR-1:0] v, input int ptr);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = NR;
    for (int i = 0; i < NR; i++) begin
      if (v[i]) begin
        d = (i - ptr + NR) % NR;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [63:0] rand_op();
    logic [63:0] x;
    x = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: x[62:52] = '0;
      1: x[62:52] = '1;
      2: begin x[62:52] = '1; x[51] = 1'b0; end
      3: begin x[62:52] = '1; x[51:0] = '0; end
      4: begin x[62:52] = '0; x[51:0] = '0; end
      default: ;
    endcase
    return x;
  endfunction

  // One clock: check ready before the edge, advance the model, check outputs after.
  task automatic step();
    logic [NR-1:0] exp_rdy;
    logic          exp_v;
    logic          rsp_hs;
    logic          req_hs;
    logic          clr;
    int            g;
    item_t         it;
    #1;
    g = ref_grant(bus.req_valid, m_ptr);
    exp_rdy = '0;
    if (g >= 0 && (q.size() < 2 || bus.rsp_ready)) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    exp_v  = (q.size() > 0) && (cyc > q[0].acc);
    rsp_hs = exp_v && bus.rsp_ready;
    req_hs = (exp_rdy != '0);
    clr    = bus.cnt_clr;
    if (req_hs) begin
      it.id   = g;
      it.data = bus.req_data[g*64 +: 64];
    end
    @(posedge clk);
    cyc++;
    if (rsp_hs) begin
      if (ref_class(q[0].data) == 10'h100 && m_cnt < CMAX) m_cnt++;
      void'(q.pop_front());
    end
    if (clr) m_cnt = 0;
    if (req_hs) begin
      it.acc = cyc;
      q.push_back(it);
      m_ptr = (g + 1) % NR;
      n_acc++;
    end
    #1;
    exp_v = (q.size() > 0) && (cyc > q[0].acc);
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_v));
    if (exp_v) begin
      chk("rsp_id", 64'(bus.rsp_id), 64'(q[0].id));
      chk("rsp_data", bus.rsp_data, q[0].data);
      chk("rsp_class", 64'(bus.rsp_class), 64'(ref_class(q[0].data)));
    end
    chk("busy", 64'(bus.busy), 64'(q.size() != 0));
    chk("snan_cnt", 64'(bus.snan_cnt), 64'(m_cnt));
  endtask

  task automatic idle(input int n);
    bus.req_valid = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  logic [63:0] cls_val [6] = '{64'h8000000000000000, 64'h0000000000000001, 64'hFFF0000000000000,
                               64'h3FF0000000000000, 64'h7FF8000000000000, 64'h7FF0000000000001};
  logic [9:0]  cls_exp [6] = '{10'h008, 10'h020, 10'h001, 10'h040, 10'h200, 10'h100};

  initial begin
    int base;
    bus.req_valid = '1;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;
    bus.cnt_clr   = 1'b0;
    #3;
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_rsp_data", bus.rsp_data, 64'd0);
    chk("rst_rsp_class", 64'(bus.rsp_class), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_snan_cnt", 64'(bus.snan_cnt), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single +inf from requester 0.
    bus.req_valid = 4'b0001;
    bus.req_data[63:0] = 64'h7FF0000000000000;
    step();
    bus.req_valid = '0;
    chk("lat_not_yet", 64'(bus.rsp_valid), 64'd0);
    step();
    chk("inf_valid", 64'(bus.rsp_valid), 64'd1);
    chk("inf_class", 64'(bus.rsp_class), 64'h080);
    chk("inf_id", 64'(bus.rsp_id), 64'd0);
    chk("inf_data", bus.rsp_data, 64'h7FF0000000000000);
    idle(2);

    // All requesters streaming with open downstream.
    for (int i = 0; i < NR; i++) bus.req_data[i*64 +: 64] = 64'h3FF0000000000000 + 64'(i);
    bus.req_valid = '1;
    base = n_acc;
    for (int i = 0; i < 12; i++) step();
    chk("stream_accepts", 64'(n_acc - base), 64'd12);
    idle(3);

    // Class coverage through requester 2.
    for (int k = 0; k < 6; k++) begin
      bus.req_valid = 4'b0100;
      bus.req_data[2*64 +: 64] = cls_val[k];
      step();
      bus.req_valid = '0;
      step();
      chk("cls_class", 64'(bus.rsp_class), 64'(cls_exp[k]));
      chk("cls_id", 64'(bus.rsp_id), 64'd2);
      if (k == 5) chk("snan_before", 64'(bus.snan_cnt), 64'd0);
      step();
      if (k == 5) chk("snan_after", 64'(bus.snan_cnt), 64'd1);
    end
    idle(2);

    // Downstream stalled while requesters 1 and 3 stream.
    bus.req_data[1*64 +: 64] = 64'h4000000000000000;
    bus.req_data[3*64 +: 64] = 64'hC000000000000000;
    bus.req_valid = 4'b1010;
    bus.rsp_ready = 1'b0;
    base = n_acc;
    for (int i = 0; i < 6; i++) step();
    chk("stall_accepts", 64'(n_acc - base), 64'd2);
    chk("stall_ready", 64'(bus.req_ready), 64'd0);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("stall_drained", 64'(q.size()), 64'd0);

    // Saturation with a 4-bit counter.
    bus.req_valid = 4'b0001;
    bus.req_data[63:0] = 64'h7FF0000000000123;
    for (int i = 0; i < 20; i++) step();
    idle(3);
    chk("snan_sat", 64'(bus.snan_cnt), 64'd15);
    bus.cnt_clr = 1'b1;
    step();
    bus.cnt_clr = 1'b0;
    chk("snan_clr", 64'(bus.snan_cnt), 64'd0);
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = '0;
    step();
    step();
    chk("snan_one", 64'(bus.snan_cnt), 64'd1);
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = '0;
    step();
    bus.cnt_clr = 1'b1;
    step();
    bus.cnt_clr = 1'b0;
    chk("snan_clr_wins", 64'(bus.snan_cnt), 64'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bus.req_valid = NR'($urandom_range(0, 15));
      for (int r = 0; r < NR; r++) bus.req_data[r*64 +: 64] = rand_op();
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      bus.cnt_clr   = ($urandom_range(0, 31) == 0);
      step();
    end
    bus.cnt_clr = 1'b0;

    // Reset with both stages full.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) step();
    chk("pre_rst_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    q.delete();
    m_ptr = 0;
    m_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    chk("post_rst_grant", 64'(bus.req_ready), 64'h2);
    step();
    bus.req_valid = '0;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
